// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// error codes and the byte width of one instruction word.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam int WORD_BYTES = 4;

  // States in which the loader still consumes stream bytes.
  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs big-endian stream bytes into 32-bit words; word is valid together
// with the fourth byte, so the caller can register it in the same cycle.
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_in,
  output logic                      word_full,
  output logic [WORD_BYTES*8-1:0]   word
);

  logic [1:0]  idx_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      idx_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_valid) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

  assign word_full = byte_valid & (idx_reg == 2'(WORD_BYTES - 1));
  assign word      = {shift_reg, byte_in};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image, writes it to instruction memory
// from address 0 and releases the core only once the frame checksum matches.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  imem_boot_loader_if.master bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [8:0]      MAX_WORDS = 9'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     n_reg, n_next;
  logic [ADDR_W:0]     count_reg, count_next, count_inc;
  logic [7:0]          xor_reg, xor_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [1:0]          code_reg, code_next;

  logic                xfer;
  logic                asm_valid;
  logic                word_full;
  logic [WORD_BYTES*8-1:0] word;
  logic [8:0]          hdr_ext;

  assign bus.rx_ready = ~clr & accepts_bytes(state_reg);
  assign xfer         = bus.rx_valid & bus.rx_ready;
  assign asm_valid    = xfer & (state_reg == DATA);
  assign hdr_ext      = {1'b0, bus.rx_data};
  assign count_inc    = count_reg + ONE;

  imem_boot_loader_word_assembler u_asm (
    .clk        (clk),
    .clr        (clr),
    .byte_valid (asm_valid),
    .byte_in    (bus.rx_data),
    .word_full  (word_full),
    .word       (word)
  );

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    count_next = count_reg;
    xor_next   = xor_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    code_next  = code_reg;

    case (state_reg)
      HDR: begin
        if (xfer) begin
          n_next   = hdr_ext[ADDR_W:0];
          xor_next = bus.rx_data;
          // Oversized images are rejected before any memory is touched.
          if (hdr_ext > MAX_WORDS) begin
            state_next = ERR;
            code_next  = ERR_LEN;
          end else if (hdr_ext == 9'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          xor_next = xor_reg ^ bus.rx_data;
          if (word_full) begin
            we_next    = 1'b1;
            addr_next  = count_reg[ADDR_W-1:0];
            wdata_next = word;
            count_next = count_inc;
            if (count_inc == n_reg) begin
              state_next = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          if (bus.rx_data == xor_reg) begin
            state_next = DONE;
          end else begin
            state_next = ERR;
            code_next  = ERR_CSUM;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= HDR;
      n_reg     <= '0;
      count_reg <= '0;
      xor_reg   <= 8'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      code_reg  <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      count_reg <= count_next;
      xor_reg   <= xor_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      code_reg  <= code_next;
    end
  end

  assign bus.imem_we    = we_reg;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;

  // Status flags decode the state register, so they only move on clk edges.
  assign cpu_hold     = (state_reg != DONE);
  assign done         = (state_reg == DONE);
  assign err          = (state_reg == ERR);
  assign err_code     = code_reg;
  assign words_loaded = count_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: a byte-count based frame model predicts every output each cycle.
module tb_imem_boot_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int MAXW   = 1 << ADDR_W;

  typedef byte unsigned bq_t[$];

  logic              clk;
  logic              clr;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame is just the list of accepted bytes; every output follows from it.
  byte unsigned      mq[$];
  bit                m_live = 1'b0;
  bit                e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_data;
  int                mk;
  int                n_strobes;
  logic [31:0]       seen_mem [MAXW];

  function automatic int m_n();
    return (mq.size() == 0) ? 0 : int'(mq[0]);
  endfunction
  function automatic bit m_overflow();
    return (mq.size() > 0) && (m_n() > MAXW);
  endfunction
  function automatic bit m_complete();
    return (mq.size() > 0) && !m_overflow() && (mq.size() == 4 * m_n() + 2);
  endfunction
  function automatic bit m_sum_ok();
    byte unsigned x = 8'd0;
    for (int i = 0; i < mq.size() - 1; i++) x ^= mq[i];
    return mq[mq.size() - 1] == x;
  endfunction
  function automatic bit m_loading();
    return (mq.size() == 0) || (!m_overflow() && (mq.size() < 4 * m_n() + 2));
  endfunction
  function automatic bit m_done();
    return m_complete() && m_sum_ok();
  endfunction
  function automatic bit m_err();
    return m_overflow() || (m_complete() && !m_sum_ok());
  endfunction
  function automatic logic [1:0] m_code();
    if (m_overflow()) return 2'b01;
    if (m_complete() && !m_sum_ok()) return 2'b10;
    return 2'b00;
  endfunction
  function automatic int m_words();
    if (mq.size() == 0 || m_overflow()) return 0;
    return (mq.size() - 1) / 4;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      mq.delete();
      e_we      = 1'b0;
      e_addr    = '0;
      e_data    = 32'd0;
      m_live    = 1'b1;
      n_strobes = 0;
      for (int i = 0; i < MAXW; i++) seen_mem[i] = 32'd0;
    end else if (m_live) begin
      e_we = 1'b0;
      if (bus.rx_valid && m_loading()) begin
        mq.push_back(bus.rx_data);
        mk = mq.size();
        // Byte k (1-based) completes a word when k-1 is a multiple of 4 inside the payload.
        if (!m_overflow() && mk >= 5 && ((mk - 1) % 4 == 0) && mk <= 4 * m_n() + 1) begin
          e_we   = 1'b1;
          e_addr = ADDR_W'((mk - 1) / 4 - 1);
          e_data = {mq[mk-4], mq[mk-3], mq[mk-2], mq[mk-1]};
        end
      end
    end
    #1;
    if (m_live) begin
      check("rx_ready",     bus.rx_ready,    !clr && m_loading());
      check("imem_we",      bus.imem_we,     e_we);
      check("imem_addr",    bus.imem_addr,   e_addr);
      check("imem_wdata",   bus.imem_wdata,  e_data);
      check("cpu_hold",     cpu_hold,        !m_done());
      check("done",         done,            m_done());
      check("err",          err,             m_err());
      check("err_code",     err_code,        m_code());
      check("words_loaded", words_loaded,    m_words());
      if (bus.imem_we === 1'b1) begin
        n_strobes++;
        seen_mem[bus.imem_addr] = bus.imem_wdata;
      end
    end
  end

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
  endtask

  // Sends until the frame ends, the model stops accepting, or stop_after bytes went out.
  task automatic send_frame(input bq_t f, input int gap_lo, input int gap_hi, input int stop_after);
    for (int i = 0; i < f.size(); i++) begin
      if (i == stop_after || !m_loading()) break;
      send_byte(f[i], $urandom_range(gap_hi, gap_lo));
    end
    #2;
  endtask

  task automatic idle_valid(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic expect_test1(input string tag);
    check({tag, "_done"},     done,          1'b1);
    check({tag, "_hold"},     cpu_hold,      1'b0);
    check({tag, "_words"},    words_loaded,  7'd2);
    check({tag, "_strobes"},  n_strobes,     2);
    check({tag, "_mem0"},     seen_mem[0],   32'h20080005);
    check({tag, "_mem1"},     seen_mem[1],   32'h01094020);
  endtask

  bq_t t1, t2, fr;
  int  n, cut;
  byte unsigned cs;

  initial begin
    clr          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    t1 = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h40, 8'h20, 8'h47};
    t2 = t1;
    t2[9] = 8'h46;

    repeat (3) @(negedge clk);
    check("rst_ready",    bus.rx_ready,  1'b0);
    check("rst_we",       bus.imem_we,   1'b0);
    check("rst_hold",     cpu_hold,      1'b1);
    check("rst_done",     done,          1'b0);
    check("rst_err",      err,           1'b0);
    check("rst_words",    words_loaded,  7'd0);
    clr = 1'b0;

    // Test 1: nominal two-word image; flags must be up right after the checksum edge.
    send_frame(t1, 0, 0, -1);
    expect_test1("t1");
    idle_valid(3);
    check("t1_strobes_after", n_strobes, 2);

    // Test 2: bad checksum.
    pulse_clr();
    send_frame(t2, 0, 0, -1);
    check("t2_err",   err,          1'b1);
    check("t2_code",  err_code,     2'b10);
    check("t2_hold",  cpu_hold,     1'b1);
    check("t2_ready", bus.rx_ready, 1'b0);
    check("t2_done",  done,         1'b0);

    // Test 3: header 65 overflows a 64-word memory.
    pulse_clr();
    fr = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr, 0, 0, -1);
    check("t3_code", err_code, 2'b01);
    check("t3_err",  err,      1'b1);
    idle_valid(6);
    check("t3_strobes", n_strobes, 0);

    // Test 4: empty image.
    pulse_clr();
    fr = '{8'h00, 8'h00};
    send_frame(fr, 0, 0, -1);
    check("t4_done",    done,         1'b1);
    check("t4_hold",    cpu_hold,     1'b0);
    check("t4_words",   words_loaded, 7'd0);
    check("t4_strobes", n_strobes,    0);

    // Test 5: valid low every other cycle.
    pulse_clr();
    send_frame(t1, 1, 1, -1);
    expect_test1("t5");

    // Test 6: abort after six payload bytes, then reload.
    pulse_clr();
    send_frame(t1, 0, 0, 7);
    pulse_clr();
    check("t6_we",    bus.imem_we,    1'b0);
    check("t6_addr",  bus.imem_addr,  6'd0);
    check("t6_wdata", bus.imem_wdata, 32'd0);
    check("t6_words", words_loaded,   7'd0);
    check("t6_hold",  cpu_hold,       1'b1);
    check("t6_done",  done,           1'b0);
    check("t6_err",   err,            1'b0);
    check("t6_code",  err_code,       2'b00);
    send_frame(t1, 0, 0, -1);
    expect_test1("t6");

    // Randomized frames: gaps, bad checksums, oversize headers, the 64-word boundary, aborts.
    for (int it = 0; it < 40; it++) begin
      pulse_clr();
      case ($urandom_range(9, 0))
        0:       n = $urandom_range(80, 65);
        1:       n = $urandom_range(64, 62);
        default: n = $urandom_range(6, 0);
      endcase
      fr.delete();
      fr.push_back(8'(n));
      cs = 8'(n);
      for (int b = 0; b < 4 * ((n > MAXW) ? 1 : n); b++) begin
        fr.push_back(8'($urandom));
        cs ^= fr[fr.size() - 1];
      end
      if ($urandom_range(4, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
      fr.push_back(cs);
      cut = ($urandom_range(5, 0) == 0) ? int'($urandom_range(fr.size() - 1, 1)) : -1;
      send_frame(fr, 0, 2, cut);
      idle_valid(3);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
